// File: rtl/sap1_pkg.sv
// rtl/sap1_pkg.sv - shared opcodes, T-state indices and opcode width for the SAP-1 sequencer
package sap1_pkg;

   localparam int OP_WIDTH = 4;

   localparam logic [3:0] OP_LDA = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_OUT = 4'b1110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   // Values double as bit positions in the one-hot t_state vector.
   typedef enum logic [2:0] {
      TS_T1   = 3'd0,
      TS_T2   = 3'd1,
      TS_T3   = 3'd2,
      TS_T4   = 3'd3,
      TS_T5   = 3'd4,
      TS_T6   = 3'd5,
      TS_HALT = 3'd6
   } tstate_e;

endpackage

// File: rtl/ring_counter.sv
// rtl/ring_counter.sv - six-step one-hot ring counter with run enable and sticky HALT
module ring_counter
   import sap1_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic       halt_req,
   output logic [5:0] ring,
   output logic       halt
);

   localparam logic [6:0] S_T1   = 7'b000_0001;
   localparam logic [6:0] S_T2   = 7'b000_0010;
   localparam logic [6:0] S_T3   = 7'b000_0100;
   localparam logic [6:0] S_T4   = 7'b000_1000;
   localparam logic [6:0] S_T5   = 7'b001_0000;
   localparam logic [6:0] S_T6   = 7'b010_0000;
   localparam logic [6:0] S_HALT = 7'b100_0000;

   logic [6:0] state;
   logic [6:0] state_next;

   always_comb begin
      state_next = state;
      if (run) begin
         case (state)
            S_T1:    state_next = S_T2;
            S_T2:    state_next = S_T3;
            S_T3:    state_next = S_T4;
            S_T4:    state_next = halt_req ? S_HALT : S_T5;
            S_T5:    state_next = S_T6;
            S_T6:    state_next = S_T1;
            S_HALT:  state_next = S_HALT;
            // Any corrupted encoding falls back to the start of an instruction.
            default: state_next = S_T1;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_T1;
      end else begin
         state <= state_next;
      end
   end

   assign ring = state[5:0];
   assign halt = state[TS_HALT];

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - SAP-1 T-state sequencer with combinational control word decode
module control_sequencer #(
   parameter int OP_WIDTH = sap1_pkg::OP_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run,
   input  logic [OP_WIDTH-1:0] ir_opcode,
   output logic                cp,
   output logic                ep,
   output logic                lm_n,
   output logic                ce_n,
   output logic                li_n,
   output logic                ei_n,
   output logic                la_n,
   output logic                lb_n,
   output logic                lo_n,
   output logic                ea,
   output logic                su,
   output logic                eu,
   output logic [5:0]          t_state,
   output logic                halted
);

   import sap1_pkg::*;

   logic [5:0] ring;
   logic       ring_halt;
   logic       is_lda;
   logic       is_add;
   logic       is_sub;
   logic       is_out;
   logic       is_hlt;

   assign is_lda = (ir_opcode == OP_WIDTH'(OP_LDA));
   assign is_add = (ir_opcode == OP_WIDTH'(OP_ADD));
   assign is_sub = (ir_opcode == OP_WIDTH'(OP_SUB));
   assign is_out = (ir_opcode == OP_WIDTH'(OP_OUT));
   assign is_hlt = (ir_opcode == OP_WIDTH'(OP_HLT));

   ring_counter u_ring_counter (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .halt_req (is_hlt),
      .ring     (ring),
      .halt     (ring_halt)
   );

   // Masking with rst keeps outputs quiet even before the first clock edge.
   assign t_state = rst ? 6'b000000 : ring;
   assign halted  = !rst && ring_halt;

   always_comb begin
      cp   = 1'b0;
      ep   = 1'b0;
      lm_n = 1'b1;
      ce_n = 1'b1;
      li_n = 1'b1;
      ei_n = 1'b1;
      la_n = 1'b1;
      lb_n = 1'b1;
      lo_n = 1'b1;
      ea   = 1'b0;
      su   = 1'b0;
      eu   = 1'b0;
      if (t_state[TS_T1]) begin
         ep   = 1'b1;
         lm_n = 1'b0;
      end else if (t_state[TS_T2]) begin
         cp   = 1'b1;
      end else if (t_state[TS_T3]) begin
         ce_n = 1'b0;
         li_n = 1'b0;
      end else if (t_state[TS_T4]) begin
         if (is_lda || is_add || is_sub) begin
            ei_n = 1'b0;
            lm_n = 1'b0;
         end else if (is_out) begin
            ea   = 1'b1;
            lo_n = 1'b0;
         end
      end else if (t_state[TS_T5]) begin
         if (is_lda) begin
            ce_n = 1'b0;
            la_n = 1'b0;
         end else if (is_add || is_sub) begin
            ce_n = 1'b0;
            lb_n = 1'b0;
         end
      end else if (t_state[TS_T6]) begin
         if (is_add || is_sub) begin
            la_n = 1'b0;
            eu   = 1'b1;
            su   = is_sub;
         end
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed self-checking bench for control_sequencer
module tb_control_sequencer;

   // Control word order: {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, lb_n, lo_n, ea, su, eu}
   localparam logic [11:0] C_IDLE  = 12'b0_0_1_1_1_1_1_1_1_0_0_0;
   localparam logic [11:0] C_T1    = 12'b0_1_0_1_1_1_1_1_1_0_0_0;
   localparam logic [11:0] C_T2    = 12'b1_0_1_1_1_1_1_1_1_0_0_0;
   localparam logic [11:0] C_T3    = 12'b0_0_1_0_0_1_1_1_1_0_0_0;
   localparam logic [11:0] C_T4MEM = 12'b0_0_0_1_1_0_1_1_1_0_0_0;
   localparam logic [11:0] C_T5LDA = 12'b0_0_1_0_1_1_0_1_1_0_0_0;
   localparam logic [11:0] C_T5ADD = 12'b0_0_1_0_1_1_1_0_1_0_0_0;
   localparam logic [11:0] C_T6ADD = 12'b0_0_1_1_1_1_0_1_1_0_0_1;
   localparam logic [11:0] C_T6SUB = 12'b0_0_1_1_1_1_0_1_1_0_1_1;
   localparam logic [11:0] C_T4OUT = 12'b0_0_1_1_1_1_1_1_0_1_0_0;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic [3:0] ir_opcode;
   logic       cp, ep, lm_n, ce_n, li_n, ei_n, la_n, lb_n, lo_n, ea, su, eu;
   logic [5:0] t_state;
   logic       halted;
   logic [11:0] ctl;

   int errors = 0;
   int checks = 0;
   logic mon_en = 1'b0;

   always #5 clk = ~clk;

   assign ctl = {cp, ep, lm_n, ce_n, li_n, ei_n, la_n, lb_n, lo_n, ea, su, eu};

   control_sequencer #(.OP_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .run(run), .ir_opcode(ir_opcode),
      .cp(cp), .ep(ep), .lm_n(lm_n), .ce_n(ce_n), .li_n(li_n), .ei_n(ei_n),
      .la_n(la_n), .lb_n(lb_n), .lo_n(lo_n), .ea(ea), .su(su), .eu(eu),
      .t_state(t_state), .halted(halted)
   );

   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if ((32'(ep) + 32'(!ei_n) + 32'(!ce_n) + 32'(ea) + 32'(eu)) > 1) begin
            errors++;
            $display("FAIL bus_driver t=%0t drivers ep=%b ei_n=%b ce_n=%b ea=%b eu=%b, required at most one", $time, ep, ei_n, ce_n, ea, eu);
         end
         checks++;
         if (!rst && !halted && !$onehot(t_state)) begin
            errors++;
            $display("FAIL onehot t=%0t t_state=%b, required one-hot", $time, t_state);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; run = 1'b0; ir_opcode = 4'b0000;
      #1;
      checks++;
      if (t_state !== 6'b0 || ctl !== C_IDLE || halted !== 1'b0) begin
         errors++;
         $display("FAIL reset_pre_edge t_state=%b ctl=%b halted=%b, required 000000 %b 0", t_state, ctl, halted, C_IDLE);
      end
      step(); step();
      checks++;
      if (t_state !== 6'b0 || ctl !== C_IDLE || halted !== 1'b0) begin
         errors++;
         $display("FAIL reset_held t_state=%b ctl=%b halted=%b, required 000000 %b 0", t_state, ctl, halted, C_IDLE);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (t_state !== 6'b000001 || ctl !== C_T1) begin
         errors++;
         $display("FAIL reset_release t_state=%b ctl=%b, required 000001 %b", t_state, ctl, C_T1);
      end
      mon_en = 1'b1;
   endtask

   task automatic test_lda();
      logic [11:0] exp_c [6] = '{C_T2, C_T3, C_T4MEM, C_T5LDA, C_IDLE, C_T1};
      logic [5:0]  exp_t [6] = '{6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b100000, 6'b000001};
      run = 1'b1; ir_opcode = 4'b0000;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (t_state !== exp_t[i] || ctl !== exp_c[i]) begin
            errors++;
            $display("FAIL lda_step%0d t_state=%b ctl=%b, required %b %b", i, t_state, ctl, exp_t[i], exp_c[i]);
         end
      end
   endtask

   task automatic test_add_sub();
      logic [11:0] sub_c [5] = '{C_T2, C_T3, C_T4MEM, C_T5ADD, C_T6SUB};
      logic [11:0] add_c [6] = '{C_T2, C_T3, C_T4MEM, C_T5ADD, C_T6ADD, C_T1};
      ir_opcode = 4'b0010;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (ctl !== sub_c[i]) begin
            errors++;
            $display("FAIL sub_step%0d ctl=%b, required %b", i, ctl, sub_c[i]);
         end
      end
      ir_opcode = 4'b0001;
      #1;
      checks++;
      if (ctl !== C_T6ADD || t_state !== 6'b100000) begin
         errors++;
         $display("FAIL opcode_change_t6 t_state=%b ctl=%b, required 100000 %b", t_state, ctl, C_T6ADD);
      end
      step();
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (ctl !== add_c[i]) begin
            errors++;
            $display("FAIL add_step%0d ctl=%b, required %b", i, ctl, add_c[i]);
         end
      end
   endtask

   task automatic test_pause();
      step(); step();
      run = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (t_state !== 6'b000100 || ctl !== C_T3) begin
            errors++;
            $display("FAIL pause_hold%0d t_state=%b ctl=%b, required 000100 %b", i, t_state, ctl, C_T3);
         end
      end
      run = 1'b1;
      step();
      checks++;
      if (t_state !== 6'b001000 || ctl !== C_T4MEM) begin
         errors++;
         $display("FAIL pause_resume t_state=%b ctl=%b, required 001000 %b", t_state, ctl, C_T4MEM);
      end
      step(); step(); step();
      checks++;
      if (t_state !== 6'b000001) begin
         errors++;
         $display("FAIL pause_wrap t_state=%b, required 000001", t_state);
      end
   endtask

   task automatic test_out_nop();
      logic [11:0] out_c [6] = '{C_T2, C_T3, C_T4OUT, C_IDLE, C_IDLE, C_T1};
      logic [11:0] nop_c [6] = '{C_T2, C_T3, C_IDLE, C_IDLE, C_IDLE, C_T1};
      ir_opcode = 4'b1110;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (ctl !== out_c[i]) begin
            errors++;
            $display("FAIL out_step%0d ctl=%b, required %b", i, ctl, out_c[i]);
         end
      end
      ir_opcode = 4'b0111;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (ctl !== nop_c[i]) begin
            errors++;
            $display("FAIL nop_step%0d ctl=%b, required %b", i, ctl, nop_c[i]);
         end
      end
      checks++;
      if (t_state !== 6'b000001) begin
         errors++;
         $display("FAIL nop_wrap t_state=%b, required 000001", t_state);
      end
   endtask

   task automatic test_rst_mid();
      ir_opcode = 4'b0001;
      step(); step(); step(); step();
      checks++;
      if (t_state !== 6'b010000 || ctl !== C_T5ADD) begin
         errors++;
         $display("FAIL mid_t5 t_state=%b ctl=%b, required 010000 %b", t_state, ctl, C_T5ADD);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (t_state !== 6'b0 || ctl !== C_IDLE) begin
         errors++;
         $display("FAIL mid_rst_immediate t_state=%b ctl=%b, required 000000 %b", t_state, ctl, C_IDLE);
      end
      step();
      rst = 1'b0;
      #1;
      checks++;
      if (t_state !== 6'b000001 || ctl !== C_T1) begin
         errors++;
         $display("FAIL mid_rst_release t_state=%b ctl=%b, required 000001 %b", t_state, ctl, C_T1);
      end
   endtask

   task automatic test_halt();
      ir_opcode = 4'b1111;
      step(); step(); step();
      checks++;
      if (t_state !== 6'b001000 || ctl !== C_IDLE || halted !== 1'b0) begin
         errors++;
         $display("FAIL hlt_t4 t_state=%b ctl=%b halted=%b, required 001000 %b 0", t_state, ctl, halted, C_IDLE);
      end
      step();
      checks++;
      if (t_state !== 6'b0 || ctl !== C_IDLE || halted !== 1'b1) begin
         errors++;
         $display("FAIL hlt_enter t_state=%b ctl=%b halted=%b, required 000000 %b 1", t_state, ctl, halted, C_IDLE);
      end
      ir_opcode = 4'b0000;
      for (int i = 0; i < 10; i++) begin
         step();
      end
      checks++;
      if (t_state !== 6'b0 || ctl !== C_IDLE || halted !== 1'b1) begin
         errors++;
         $display("FAIL hlt_sticky t_state=%b ctl=%b halted=%b, required 000000 %b 1", t_state, ctl, halted, C_IDLE);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      checks++;
      if (t_state !== 6'b000001 || ctl !== C_T1 || halted !== 1'b0) begin
         errors++;
         $display("FAIL hlt_exit t_state=%b ctl=%b halted=%b, required 000001 %b 0", t_state, ctl, halted, C_T1);
      end
   endtask

   initial begin
      test_reset();
      test_lda();
      test_add_sub();
      test_pause();
      test_out_nop();
      test_rst_mid();
      test_halt();
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
